// File: rtl/proc_pkg.sv
// Shared definitions for the processor sequencing controller: opcodes,
// time-step encoding and instruction-register field positions.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    localparam int unsigned IR_W = 9;

    // IR[8:0] = III XXX YYY
    localparam int unsigned OP_MSB = 8;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RX_MSB = 5;
    localparam int unsigned RX_LSB = 3;
    localparam int unsigned RY_MSB = 2;
    localparam int unsigned RY_LSB = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit to one-hot 8-bit decoder with an active-high enable.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] w,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Sequencing controller: latches an instruction in T0, then steps T1..T3
// driving register enables, bus selects and ALU controls (Moore outputs).
module proc_control
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [7:0]        Rin,
    output logic [7:0]        Rout,
    output logic              DINout,
    output logic              Gout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done
);

    state_e          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [2:0] op, rx, ry;
    logic [7:0] x_oh, y_oh;
    logic       ir_in, rin_x_en, rout_x_en, rout_y_en;
    logic       din_out, g_out, a_in, g_in, add_sub, done;
    logic       unused_din;

    assign unused_din = ^DIN[DATA_W-1:IR_W];

    assign op = ir_q[OP_MSB:OP_LSB];
    assign rx = ir_q[RX_MSB:RX_LSB];
    assign ry = ir_q[RY_MSB:RY_LSB];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[IR_W-1:0];
                    state_d = T1;
                end
            end
            T1:      state_d = is_arith(op) ? T2 : T0;
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    always_comb begin
        ir_in     = 1'b0;
        rin_x_en  = 1'b0;
        rout_x_en = 1'b0;
        rout_y_en = 1'b0;
        din_out   = 1'b0;
        g_out     = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        add_sub   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            // State is already forced to T0 during reset; only IRin sees Run.
            T0: ir_in = Run && !Reset;
            T1: begin
                unique case (op)
                    OP_MV: begin
                        rout_y_en = 1'b1;
                        rin_x_en  = 1'b1;
                        done      = 1'b1;
                    end
                    OP_MVI: begin
                        din_out  = 1'b1;
                        rin_x_en = 1'b1;
                        done     = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_x_en = 1'b1;
                        a_in      = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                rout_y_en = 1'b1;
                g_in      = 1'b1;
                add_sub   = ir_q[OP_LSB];
            end
            T3: begin
                g_out    = 1'b1;
                rin_x_en = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    dec3to8 u_dec_x (
        .en (!Reset),
        .w  (rx),
        .y  (x_oh)
    );

    dec3to8 u_dec_y (
        .en (!Reset),
        .w  (ry),
        .y  (y_oh)
    );

    assign IRin   = ir_in;
    assign Rin    = rin_x_en ? x_oh : '0;
    assign Rout   = (rout_x_en ? x_oh : '0) | (rout_y_en ? y_oh : '0);
    assign DINout = din_out;
    assign Gout   = g_out;
    assign Ain    = a_in;
    assign Gin    = g_in;
    assign AddSub = add_sub;
    assign Done   = done;

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: stimulus pushes per-cycle expected
// output vectors, a negedge monitor pops and compares them.
module tb_proc_control;

    logic        Clock, Reset, Run;
    logic [15:0] DIN;
    logic        IRin, DINout, Gout, Ain, Gin, AddSub, Done;
    logic [7:0]  Rin, Rout;

    typedef struct {
        logic [22:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    proc_control #(.DATA_W(16)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .DIN    (DIN),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .DINout (DINout),
        .Gout   (Gout),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Done   (Done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}
    function automatic logic [22:0] ex(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic dinout,
                                       input logic gout, input logic ain,
                                       input logic gin, input logic addsub,
                                       input logic done);
        return {irin, rin, rout, dinout, gout, ain, gin, addsub, done};
    endfunction

    localparam logic [22:0] Z = '0;

    task automatic cyc(input logic rst, input logic run, input logic [15:0] din,
                       input logic [22:0] e, input string nm);
        exp_t item;
        @(posedge Clock);
        #1;
        Reset = rst;
        Run   = run;
        DIN   = din;
        item.v    = e;
        item.name = nm;
        q.push_back(item);
    endtask

    initial begin : monitor
        exp_t        item;
        logic [22:0] act;
        forever begin
            @(negedge Clock);
            act = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};
            checks++;
            if (($countones(Rout) + int'(Gout) + int'(DINout)) > 1) begin
                errors++;
                $display("FAIL bus_exclusive: Rout=%h Gout=%b DINout=%b, at most one source required",
                         Rout, Gout, DINout);
            end
            if (q.size() > 0) begin
                item = q.pop_front();
                checks++;
                if (act !== item.v) begin
                    errors++;
                    $display("FAIL %s: got IRin=%b Rin=%h Rout=%h DINout=%b Gout=%b Ain=%b Gin=%b AddSub=%b Done=%b, expected %b_%h_%h_%b%b%b%b%b%b",
                             item.name, IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done,
                             item.v[22], item.v[21:14], item.v[13:6], item.v[5], item.v[4],
                             item.v[3], item.v[2], item.v[1], item.v[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int unsigned wait_cnt;
        Reset = 1'b1;
        Run   = 1'b1;
        DIN   = '0;

        cyc(1, 1, 16'h0000, Z, "reset_irin_masked");
        cyc(0, 0, 16'h0000, Z, "idle_t0");

        // mv R3,R5
        cyc(0, 1, 16'b000_011_101, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "mv_t0_irin");
        cyc(0, 0, 16'h0000, ex(0, 8'h08, 8'h20, 0, 0, 0, 0, 0, 1), "mv_t1");
        cyc(0, 0, 16'h0000, Z, "mv_back_t0");

        // mvi R2,#A5
        cyc(0, 1, 16'b001_010_000, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "mvi_t0_irin");
        cyc(0, 0, 16'h00A5, ex(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1), "mvi_t1");
        cyc(0, 0, 16'h0000, Z, "mvi_back_t0");

        // sub R1,R6 with Run toggling mid-instruction
        cyc(0, 1, 16'b011_001_110, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "sub_t0_irin");
        cyc(0, 0, 16'h0000, ex(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0), "sub_t1");
        cyc(0, 1, 16'h01FF, ex(0, 8'h00, 8'h40, 0, 0, 0, 1, 1, 0), "sub_t2");
        cyc(0, 0, 16'h0000, ex(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1), "sub_t3");
        cyc(0, 0, 16'h0000, Z, "sub_back_t0");

        // add R1,R6 then mv R7,R0 then mv R4,R4, Run held high
        cyc(0, 1, 16'b010_001_110, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "add_t0_irin");
        cyc(0, 1, 16'b000_111_000, ex(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0), "add_t1");
        cyc(0, 1, 16'b000_111_000, ex(0, 8'h00, 8'h40, 0, 0, 0, 1, 0, 0), "add_t2");
        cyc(0, 1, 16'b000_111_000, ex(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1), "add_t3");
        cyc(0, 1, 16'b000_111_000, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "b2b_irin");
        cyc(0, 1, 16'b000_100_100, ex(0, 8'h80, 8'h01, 0, 0, 0, 0, 0, 1), "mv_r7_r0_t1");
        cyc(0, 1, 16'b000_100_100, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "mv_r4_irin");
        cyc(0, 0, 16'h0000, ex(0, 8'h10, 8'h10, 0, 0, 0, 0, 0, 1), "mv_rx_rx_t1");
        cyc(0, 0, 16'h0000, Z, "b2b_back_t0");

        // add R2,R3 aborted by reset in T2
        cyc(0, 1, 16'b010_010_011, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "abort_t0_irin");
        cyc(0, 0, 16'h0000, ex(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0), "abort_t1");
        cyc(1, 0, 16'h0000, Z, "abort_reset_t2");
        cyc(0, 0, 16'h0000, Z, "abort_release");
        cyc(0, 0, 16'h0000, Z, "abort_no_done");

        // undefined opcode 111
        cyc(0, 1, 16'b111_101_010, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "nop_t0_irin");
        cyc(0, 0, 16'h0000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1), "nop_t1");
        cyc(0, 0, 16'h0000, Z, "nop_back_t0");

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge Clock);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, 0 required", q.size());
        end
        @(posedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_control.md
# proc_control

Sequencing controller for the 16-bit bus-based processor. It latches a 9-bit instruction from `DIN`, decodes it, and steps through time-steps T0–T3. In each step it drives the register-file enables, the bus-source selects, the accumulator/result-register loads, and the `AddSub` select consumed by the adder/subtractor. It is the initiator for every datapath transfer; the datapath only responds to its strobes.

## Interface
- `DATA_W`, default 16: width of `DIN`; only bits [8:0] are used as the instruction.
- `Clock`, in, 1: the only clock; all state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-high; forces state to T0 and `IR` to 0.
- `Run`, in, 1: start request; sampled in T0 only.
- `DIN`, in, `DATA_W`: instruction in T0, immediate operand in T1 of `mvi`.
- `IRin`, out, 1: instruction-register load strobe (informational copy of the internal load).
- `Rin`, out, 8: one-hot register load enables R0–R7.
- `Rout`, out, 8: one-hot register bus-drive selects R0–R7.
- `DINout`, out, 1: `DIN` drives the bus.
- `Gout`, out, 1: result register G drives the bus.
- `Ain`, out, 1: load accumulator A from the bus.
- `Gin`, out, 1: load G from the adder/subtractor output.
- `AddSub`, out, 1: 0 selects A+bus, 1 selects A−bus.
- `Done`, out, 1: the last step of the instruction completes this cycle.

## Operation
- Instruction format, `IR[8:0]` = `III XXX YYY`: opcode `III`, destination/first operand `Rx`, source `Ry`.
- Opcodes:
  - 000 = `mv Rx,Ry`
  - 001 = `mvi Rx,#D`
  - 010 = `add Rx,Ry`
  - 011 = `sub Rx,Ry`
  - 100–111 are undefined and are treated as NOP.
- States: T0, T1, T2, T3, 2-bit encoded.
- T0:
  - If `Run`=1: assert `IRin`, load `IR`←`DIN[8:0]`, go to T1.
  - If `Run`=0: stay in T0, all outputs 0.
- T1:
  - `mv`: `Rout[Y]`, `Rin[X]`, `Done` → T0.
  - `mvi`: `DINout`, `Rin[X]`, `Done` → T0.
  - `add`/`sub`: `Rout[X]`, `Ain` → T2.
  - NOP: `Done` only → T0.
- T2 (`add`/`sub`): `Rout[Y]`, `Gin`, `AddSub` = `IR[6]` (0 for add, 1 for sub) → T3.
- T3 (`add`/`sub`): `Gout`, `Rin[X]`, `Done` → T0.
- Outputs are combinational from the state and `IR` (Moore style), except `IRin`, which also depends on `Run`.
- Bus exclusivity invariant: at most one of {any `Rout` bit, `Gout`, `DINout`} is 1 in any cycle.
- `AddSub` is 0 in every state except T2 of `sub`.
- `mv Rx,Rx` is legal: `Rout[X]` and `Rin[X]` are asserted together.
- `Run` is ignored outside T0; an instruction always completes once started.

## Timing
- Latency, counted from the T0 cycle with `Run`=1 to the `Done` cycle:
  - `mv`/`mvi`/NOP: 1 cycle (`Done` in T1).
  - `add`/`sub`: 3 cycles (`Done` in T3).
- Back-to-back issue: the cycle after `Done` is T0; if `Run` is held at 1, the next instruction is latched there. Throughput is 2 cycles for `mv`, 4 cycles for `add`.
- `Done` is high for exactly one cycle per instruction.
- Reset values: state T0, `IR`=0. Every output is 0 while `Reset`=1, including `IRin` regardless of `Run`.
- Reset mid-instruction (any of T1–T3): outputs drop on assertion without waiting for a clock edge, no `Done` is produced, and no partial `Rin` fires after release. The first edge after release with `Run`=1 latches a new instruction.
- `DIN` must be stable across the rising edge ending T0 (instruction) and across the edge ending T1 of `mvi` (immediate).

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - state encoding `T0`..`T3`;
  - the field positions of `IR`.
- Sub-module `dec3to8`: 3-bit to one-hot 8-bit decoder with an enable. Instantiate it twice, for `XXX` and `YYY`; gate each decoder's outputs per state to form `Rin` and `Rout`.
- Keep the state register and `IR` register in one sequential process, and the output decode in one combinational process.

## Test plan
- Reset, then `Run`=1 with `DIN`=9'b000_011_101 → `IRin`=1 in T0. Next cycle: `Rout`=8'h20, `Rin`=8'h08, `Done`=1. Then T0.
- `DIN`=9'b001_010_000, then `DIN`=16'h00A5 in T1 → `DINout`=1, `Rin`=8'h04, `Done`=1 in T1. `Gout`, `Rout` and `Ain` stay 0 throughout.
- `sub R1,R6` (9'b011_001_110):
  - T1: `Rout`=8'h02, `Ain`=1.
  - T2: `Rout`=8'h40, `Gin`=1, `AddSub`=1.
  - T3: `Gout`=1, `Rin`=8'h02, `Done`=1.
  - The same instruction with opcode 010 gives `AddSub`=0 in T2.
- `Run` held at 1 across `add` followed by `mv` → the second `IRin` occurs in the cycle immediately after the T3 `Done`. `Run` toggling during T1–T3 has no effect.
- Assert `Reset` during T2 of `add` → all outputs 0 within the same cycle. After release with `Run`=0, state stays T0 and no `Done` appears.
- Opcode 111 → only `Done`=1 in T1 with all other outputs 0, then return to T0.
- Assert the bus-exclusivity invariant in every cycle of every test.
